// File: rtl/sl3p_pkg.sv
// Shared SL3P types and default widths for the RX lane path.
package sl3p_pkg;

  localparam int unsigned SL3P_WORD_W          = 64;
  localparam int unsigned SL3P_SKEW_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACK    = 2'd1,
    SETTLE   = 2'd2
  } skew_state_t;

endpackage

// File: rtl/sl3p_skew_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// A same-address read during a write returns the word being written, which
// lets a zero-word delay pass din straight through with one clock of latency.
//  clk    in  clock
//  we     in  write enable
//  waddr  in  write address
//  wdata  in  write data
//  re     in  read enable (rdata holds when low)
//  raddr  in  read address
//  rdata  out registered read data
module sl3p_skew_ram #(
  parameter int unsigned DATA_W = 65,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port plus write-first registered read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/sl3p_lane_skew_buf.sv
// Per-lane programmable delay line between word lock and the deskew monitor.
// Each fallback_req adds one word of delay; am_ping flags a marker leaving.
//  clk          in  RX word clock
//  arst_n       in  asynchronous reset, active-low
//  word_locked  in  lane word lock; low flushes and restarts
//  din/din_am   in  locked word and its marker flag, qualified by din_valid
//  fallback_req in  one-cycle request for one more word of delay
//  dout         out delayed word (holds while dout_valid is low)
//  dout_valid   out dout qualifier
//  am_ping      out dout is a marker word
//  delay        out current delay in valid words
//  delay_ovf    out sticky: request arrived at max delay
module sl3p_lane_skew_buf
  import sl3p_pkg::*;
#(
  parameter int unsigned WIDTH      = SL3P_WORD_W,
  parameter int unsigned DEPTH_LOG2 = SL3P_SKEW_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  word_locked,
  input  logic [WIDTH-1:0]      din,
  input  logic                  din_am,
  input  logic                  din_valid,
  input  logic                  fallback_req,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  am_ping,
  output logic [DEPTH_LOG2-1:0] delay,
  output logic                  delay_ovf
);

  localparam int unsigned           DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned           FILL_W    = DEPTH_LOG2 + 1;
  localparam logic [FILL_W-1:0]     FILL_MAX  = FILL_W'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] DELAY_MAX = '1;

  skew_state_t           state, state_nxt;
  logic [DEPTH_LOG2-1:0] wp, wp_nxt, delay_nxt, rd_addr;
  logic [FILL_W-1:0]     fill, fill_nxt;
  logic                  ovf_nxt, active, wr_en, rd_en, rd_seen;
  logic [WIDTH:0]        rd_word;

  // Datapath runs only once the FSM has left UNLOCKED and lock still holds
  assign active  = word_locked && (state != UNLOCKED);
  assign wr_en   = active && din_valid;
  assign rd_en   = wr_en && (fill > FILL_W'(delay));
  assign rd_addr = wp - delay;

  sl3p_skew_ram #(
    .DATA_W (WIDTH + 1),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wp),
    .wdata ({din_am, din}),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // RAM read register has no reset; mask dout until the first real read
  assign dout    = rd_seen ? rd_word[WIDTH-1:0] : '0;
  assign am_ping = dout_valid && rd_word[WIDTH];

  // Next-state, pointer, fill and delay control
  always_comb begin
    state_nxt = state;
    wp_nxt    = wp;
    fill_nxt  = fill;
    delay_nxt = delay;
    ovf_nxt   = delay_ovf;
    if (!word_locked) begin
      state_nxt = UNLOCKED;
      wp_nxt    = '0;
      fill_nxt  = '0;
      delay_nxt = '0;
      ovf_nxt   = 1'b0;
    end else begin
      if (wr_en) begin
        wp_nxt = wp + 1'b1;
        if (fill != FILL_MAX) fill_nxt = fill + 1'b1;
      end
      unique case (state)
        UNLOCKED: state_nxt = TRACK;
        TRACK: begin
          if (fallback_req) begin
            if (delay != DELAY_MAX) begin
              delay_nxt = delay + 1'b1;
              state_nxt = SETTLE;
            end else begin
              ovf_nxt = 1'b1;
            end
          end
        end
        // Requests ignored until the monitor sees a ping at the new delay
        SETTLE: if (am_ping) state_nxt = TRACK;
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  // State and control registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= UNLOCKED;
      wp         <= '0;
      fill       <= '0;
      delay      <= '0;
      delay_ovf  <= 1'b0;
      dout_valid <= 1'b0;
      rd_seen    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wp         <= wp_nxt;
      fill       <= fill_nxt;
      delay      <= delay_nxt;
      delay_ovf  <= ovf_nxt;
      dout_valid <= rd_en;
      rd_seen    <= rd_seen || rd_en;
    end
  end

endmodule

// File: tb/tb_sl3p_lane_skew_buf.sv
module tb_sl3p_lane_skew_buf;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        word_locked;
  logic [63:0] din;
  logic        din_am;
  logic        din_valid;
  logic        fallback_req;
  logic [63:0] dout;
  logic        dout_valid;
  logic        am_ping;
  logic [3:0]  delay;
  logic        delay_ovf;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  sl3p_lane_skew_buf #(.WIDTH(64), .DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .word_locked  (word_locked),
    .din          (din),
    .din_am       (din_am),
    .din_valid    (din_valid),
    .fallback_req (fallback_req),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .am_ping      (am_ping),
    .delay        (delay),
    .delay_ovf    (delay_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: history of the last 16 valid words, plus lane delay bookkeeping
  logic [64:0] hist[$];
  int          m_cnt    = 0;
  int          m_delay  = 0;
  bit          m_active = 0;
  bit          m_settle = 0;
  bit          m_ovf    = 0;
  bit          e_dv     = 0;
  bit          e_am     = 0;
  logic [63:0] e_dout   = '0;

  always @(posedge clk) begin
    int          fill, d_old;
    bit          am_prev;
    logic [64:0] w;
    if (!arst_n) begin
      m_active = 0; m_settle = 0; m_delay = 0; m_ovf = 0; m_cnt = 0;
      hist.delete(); e_dv = 0; e_am = 0; e_dout = '0;
    end else if (!word_locked) begin
      m_active = 0; m_settle = 0; m_delay = 0; m_ovf = 0; m_cnt = 0;
      hist.delete(); e_dv = 0; e_am = 0;
    end else if (!m_active) begin
      m_active = 1; e_dv = 0; e_am = 0;
    end else begin
      am_prev = e_am;
      d_old   = m_delay;
      if (m_settle) begin
        if (am_prev) m_settle = 0;
      end else if (fallback_req) begin
        if (m_delay < 15) begin m_delay++; m_settle = 1; end
        else m_ovf = 1;
      end
      e_dv = 0; e_am = 0;
      if (din_valid) begin
        fill = (m_cnt > 16) ? 16 : m_cnt;
        hist.push_back({din_am, din});
        if (hist.size() > 16) void'(hist.pop_front());
        m_cnt++;
        if (fill > d_old) begin
          w      = hist[hist.size() - 1 - d_old];
          e_dv   = 1;
          e_am   = w[64];
          e_dout = w[63:0];
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (arst_n && chk_en) begin
      chk("dout_valid", 64'(dout_valid), 64'(e_dv));
      chk("am_ping", 64'(am_ping), 64'(e_am));
      chk("dout", dout, e_dout);
      chk("delay", 64'(delay), 64'(m_delay));
      chk("delay_ovf", 64'(delay_ovf), 64'(m_ovf));
    end
  end

  int vmode = 0;
  int am_period = 0;
  int pat_i = 0;
  int wcnt = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bit v;
    case (vmode)
      0:       v = 1'b1;
      1:       v = (pat_i % 4) != 2;
      default: v = 1'($urandom_range(0, 1));
    endcase
    pat_i++;
    din_valid = v;
    din       = {$urandom, $urandom};
    din_am    = v && (am_period != 0) && ((wcnt % am_period) == am_period - 1);
    if (v) wcnt++;
    cyc();
  endtask

  // One fallback request, then wait for the ping that returns the lane to tracking
  task automatic bump();
    fallback_req = 1'b1;
    tick();
    fallback_req = 1'b0;
    for (int k = 0; k < 200 && !am_ping; k++) tick();
    checks++;
    if (!am_ping) begin
      failures++;
      $display("FAIL bump_ping_timeout actual=0 expected=1 t=%0t", $time);
    end
    tick();
  endtask

  task automatic relock();
    word_locked = 1'b0;
    tick();
    word_locked = 1'b1;
    tick();
  endtask

  task automatic marker_latency(output int lat);
    din_valid = 1'b1; din_am = 1'b1; din = {$urandom, $urandom};
    cyc();
    lat = 1;
    while (!am_ping && lat < 50) begin
      din_valid = 1'b1; din_am = 1'b0; din = {$urandom, $urandom};
      cyc();
      lat++;
    end
  endtask

  initial begin
    logic [63:0] words [12];
    int lat;
    arst_n = 1'b0; word_locked = 1'b0; din = '0; din_am = 1'b0;
    din_valid = 1'b0; fallback_req = 1'b0;
    repeat (3) cyc();
    chk("rst_dout", dout, 64'h0);
    chk("rst_dout_valid", 64'(dout_valid), 64'h0);
    chk("rst_am_ping", 64'(am_ping), 64'h0);
    chk("rst_delay", 64'(delay), 64'h0);
    chk("rst_delay_ovf", 64'(delay_ovf), 64'h0);
    arst_n = 1'b1;
    chk_en = 1'b1;

    // Lock and stream at delay 0: marker on word 10 pings one clock later
    word_locked = 1'b1;
    cyc();
    for (int i = 0; i < 12; i++) begin
      words[i]  = {$urandom, $urandom};
      din       = words[i];
      din_am    = (i == 10);
      din_valid = 1'b1;
      cyc();
      if (i >= 1) begin
        chk("t1_dout", dout, words[i]);
        chk("t1_dv", 64'(dout_valid), 64'h1);
        chk("t1_am", 64'(am_ping), 64'(i == 10));
      end
    end

    // Two requests with no ping in between: one increment only
    am_period = 0;
    fallback_req = 1'b1; tick(); fallback_req = 1'b0; tick();
    fallback_req = 1'b1; tick(); fallback_req = 1'b0; tick();
    chk("t3_delay", 64'(delay), 64'h1);
    relock();
    chk("t3_relock_delay", 64'(delay), 64'h0);

    // Three paced requests then measure marker latency
    am_period = 8;
    repeat (20) tick();
    repeat (3) bump();
    chk("t2_delay", 64'(delay), 64'h3);
    am_period = 0;
    repeat (20) tick();
    marker_latency(lat);
    chk("t2_latency", 64'(lat), 64'h4);

    // Valid gaps 1101 at delay 2
    relock();
    am_period = 5;
    repeat (20) tick();
    repeat (2) bump();
    chk("t5_delay", 64'(delay), 64'h2);
    vmode = 1;
    repeat (60) tick();

    // Saturate at 15 and overflow
    vmode = 0; am_period = 4;
    for (int i = 0; i < 13; i++) bump();
    chk("t4_delay_max", 64'(delay), 64'hf);
    fallback_req = 1'b1; tick(); fallback_req = 1'b0; tick();
    chk("t4_delay_hold", 64'(delay), 64'hf);
    chk("t4_ovf", 64'(delay_ovf), 64'h1);
    word_locked = 1'b0; tick();
    chk("t4_ovf_clr", 64'(delay_ovf), 64'h0);
    word_locked = 1'b1; tick();

    // Unlock one clock before a marker exits at delay 3
    am_period = 6;
    repeat (20) tick();
    repeat (3) bump();
    am_period = 0;
    repeat (20) tick();
    din_valid = 1'b1; din_am = 1'b1; din = {$urandom, $urandom}; cyc();
    din_am = 1'b0;
    repeat (2) begin din = {$urandom, $urandom}; cyc(); end
    word_locked = 1'b0;
    din = {$urandom, $urandom}; cyc();
    chk("t6_am", 64'(am_ping), 64'h0);
    chk("t6_dv", 64'(dout_valid), 64'h0);
    word_locked = 1'b1; tick(); tick();
    chk("t6_delay", 64'(delay), 64'h0);

    // Randomised traffic, requests and occasional unlocks
    vmode = 2; am_period = 6;
    for (int i = 0; i < 1500; i++) begin
      fallback_req = ($urandom_range(0, 9) == 0);
      word_locked  = ($urandom_range(0, 299) != 0);
      tick();
    end
    fallback_req = 1'b0; word_locked = 1'b1;
    repeat (4) tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
